scene_platform_engine: RTL and testbench
========================================

SCENE_PLATFORM_ENGINE -- requirements
Module: scene_platform_engine

Interface
REQ-001 The module SHALL have parameter CHAR_W, default 10: character sprite width in pixels.
REQ-002 The module SHALL have parameter CHAR_H, default 10: character sprite height in pixels.
REQ-003 The module SHALL have parameter CHAR_COLOUR, default 3'b100: character pixel colour.
REQ-004 The module SHALL have parameter PLAT_COLOUR, default 3'b010: platform pixel colour.
REQ-005 Port clock, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-006 Port resetn, input, 1 bit: reset, synchronous, active-low.
REQ-007 Port pix_x, input, 9 bits: scan pixel column, range 0..319.
REQ-008 Port pix_y, input, 9 bits: scan pixel row, range 0..239.
REQ-009 Port char_x, input, 9 bits: character top-left column.
REQ-010 Port char_y, input, 9 bits: character top-left row.
REQ-011 Port bg_colour, output, 3 bits: PLAT_COLOUR if the scan pixel is on a platform, else 3'b000.
REQ-012 Port char_colour, output, 3 bits: CHAR_COLOUR if the scan pixel is inside the character, else the 3'b111 sentinel.
REQ-013 Ports coll_down, coll_up, coll_left and coll_right, outputs, 3 bits each: PLAT_COLOUR if that edge touches a solid area, else 3'b000.

Function
REQ-014 Platforms SHALL be these fixed inclusive rectangles, as (x0..x1, y0..y1):
- P0 (0..319, 215..239), the floor
- P1 (80..159, 170..179)
- P2 (180..259, 120..129)
- P3 (0..9, 0..239), the left wall
- P4 (310..319, 0..239), the right wall
REQ-015 bg_colour SHALL be PLAT_COLOUR when (pix_x, pix_y) lies in any platform.
REQ-016 char_colour SHALL be CHAR_COLOUR when char_x <= pix_x <= char_x+CHAR_W-1 and char_y <= pix_y <= char_y+CHAR_H-1; all sums SHALL be computed at 10 bits so they never wrap.
REQ-017 The four probe segments SHALL be:
- down: row char_y+CHAR_H, columns char_x..char_x+CHAR_W-1
- up: row char_y-1, same columns
- left: column char_x-1, rows char_y..char_y+CHAR_H-1
- right: column char_x+CHAR_W, same rows
REQ-018 A probe SHALL report PLAT_COLOUR if any of its pixels lies in a platform or off-screen (column > 319, row > 239, or a -1 underflow).
REQ-019 All outputs SHALL be registered, with exactly 1-cycle latency from the inputs; no combinational input-to-output path.
REQ-020 The four probes SHALL be independent; simultaneous contacts SHALL all assert in the same cycle.
REQ-021 Changes to char_x/char_y SHALL be reflected in every output in the next cycle.

Reset
REQ-022 While resetn=0 at a clock edge, the outputs SHALL load: bg_colour=3'b000, char_colour=3'b111, all coll_*=3'b000.
REQ-023 Normal 1-cycle operation SHALL resume on the first edge with resetn=1; a reset mid-scan SHALL discard the in-flight result.

Structure
REQ-024 A shared package SHALL hold the platform rectangle table, the screen limits 320x240, and the colour constants.
REQ-025 One sub-module, plat_span_check, SHALL test a horizontal or vertical segment against the platform table and the screen bounds.
REQ-026 plat_span_check SHALL be instantiated five times: four probes plus a 1-pixel render span.

Verification
REQ-027 Floor rest: char=(35,205) -> coll_down=010; coll_up=000; coll_left=000; coll_right=000.
REQ-028 Airborne: char=(100,150) -> coll_down=000, one cycle after the input change.
REQ-029 Under-platform and wall cases:
- char=(100,180) -> coll_up=010
- char=(10,100) -> coll_left=010
- char=(300,100) -> coll_right=010
REQ-030 Render cases:
- pix=(85,175) -> bg_colour=010
- pix=(85,165) -> bg_colour=000
- char=(35,205): pix=(44,214) -> char_colour=100; pix=(45,214) -> char_colour=111
REQ-031 Edge, corner and reset cases:
- char=(0,0) -> coll_up=010 and coll_left=010 in the same cycle
- resetn=0 mid-scan -> bg_colour=000, char_colour=111, coll_*=000 at the next edge

Source files
------------

// File: rtl/scene_platform_engine_pkg.sv
// Shared screen geometry, platform table and colour constants for the scene engine.
package scene_platform_engine_pkg;

  typedef logic [9:0] coord_t;

  typedef struct packed {
    coord_t x0;
    coord_t x1;
    coord_t y0;
    coord_t y1;
  } rect_t;

  localparam coord_t SCREEN_W = 10'd320;
  localparam coord_t SCREEN_H = 10'd240;

  localparam logic [2:0] COLOUR_BLACK    = 3'b000;
  localparam logic [2:0] COLOUR_NONE     = 3'b111;
  localparam logic [2:0] DEF_CHAR_COLOUR = 3'b100;
  localparam logic [2:0] DEF_PLAT_COLOUR = 3'b010;

  localparam int NUM_PLATS = 5;

  // Index 0 is the floor; the rest follow in order up to the right wall.
  localparam rect_t [NUM_PLATS-1:0] PLAT_TABLE = {
    rect_t'{x0: 10'd310, x1: 10'd319, y0: 10'd0,   y1: 10'd239},
    rect_t'{x0: 10'd0,   x1: 10'd9,   y0: 10'd0,   y1: 10'd239},
    rect_t'{x0: 10'd180, x1: 10'd259, y0: 10'd120, y1: 10'd129},
    rect_t'{x0: 10'd80,  x1: 10'd159, y0: 10'd170, y1: 10'd179},
    rect_t'{x0: 10'd0,   x1: 10'd319, y0: 10'd215, y1: 10'd239}
  };

  function automatic logic rects_overlap(input rect_t a, input rect_t b);
    return (a.x0 <= b.x1) && (b.x0 <= a.x1) && (a.y0 <= b.y1) && (b.y0 <= a.y1);
  endfunction

endpackage

// File: rtl/scene_platform_engine_plat_span_check.sv
// Tests an axis-aligned pixel span against the platform table and the screen bounds.
module plat_span_check
  import scene_platform_engine_pkg::*;
(
  input  logic [9:0] x0,
  input  logic [9:0] x1,
  input  logic [9:0] y0,
  input  logic [9:0] y1,
  output logic       plat_hit,
  output logic       off_screen
);

  rect_t span;

  always_comb begin
    span     = '{x0: x0, x1: x1, y0: y0, y1: y1};
    plat_hit = 1'b0;
    for (int i = 0; i < NUM_PLATS; i++) begin
      if (rects_overlap(span, PLAT_TABLE[i])) plat_hit = 1'b1;
    end
    // A -1 underflow wraps to 1023 at 10 bits, so it lands in the off-screen test too.
    off_screen = (x1 >= SCREEN_W) || (y1 >= SCREEN_H);
  end

endmodule

// File: rtl/scene_platform_engine.sv
// Renders platform/character colours for the scan pixel and reports edge contacts
// of the character against platforms and screen bounds, all with one cycle of latency.
module scene_platform_engine
  import scene_platform_engine_pkg::*;
#(
  parameter int         CHAR_W      = 10,
  parameter int         CHAR_H      = 10,
  parameter logic [2:0] CHAR_COLOUR = DEF_CHAR_COLOUR,
  parameter logic [2:0] PLAT_COLOUR = DEF_PLAT_COLOUR
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [8:0] pix_x,
  input  logic [8:0] pix_y,
  input  logic [8:0] char_x,
  input  logic [8:0] char_y,
  output logic [2:0] bg_colour,
  output logic [2:0] char_colour,
  output logic [2:0] coll_down,
  output logic [2:0] coll_up,
  output logic [2:0] coll_left,
  output logic [2:0] coll_right
);

  localparam coord_t W = coord_t'(CHAR_W);
  localparam coord_t H = coord_t'(CHAR_H);

  coord_t px, py, cx, cy;
  coord_t cx_last, cy_last, cx_before, cy_before, cx_after, cy_after;

  assign px        = {1'b0, pix_x};
  assign py        = {1'b0, pix_y};
  assign cx        = {1'b0, char_x};
  assign cy        = {1'b0, char_y};
  assign cx_last   = cx + W - 10'd1;
  assign cy_last   = cy + H - 10'd1;
  assign cx_before = cx - 10'd1;
  assign cy_before = cy - 10'd1;
  assign cx_after  = cx + W;
  assign cy_after  = cy + H;

  logic down_hit, down_off, up_hit, up_off;
  logic left_hit, left_off, right_hit, right_off;
  logic pix_hit, pix_off;

  plat_span_check u_down  (.x0(cx),        .x1(cx_last),   .y0(cy_after),  .y1(cy_after),
                           .plat_hit(down_hit),  .off_screen(down_off));
  plat_span_check u_up    (.x0(cx),        .x1(cx_last),   .y0(cy_before), .y1(cy_before),
                           .plat_hit(up_hit),    .off_screen(up_off));
  plat_span_check u_left  (.x0(cx_before), .x1(cx_before), .y0(cy),        .y1(cy_last),
                           .plat_hit(left_hit),  .off_screen(left_off));
  plat_span_check u_right (.x0(cx_after),  .x1(cx_after),  .y0(cy),        .y1(cy_last),
                           .plat_hit(right_hit), .off_screen(right_off));
  plat_span_check u_pixel (.x0(px),        .x1(px),        .y0(py),        .y1(py),
                           .plat_hit(pix_hit),   .off_screen(pix_off));

  logic char_inside;
  assign char_inside = (px >= cx) && (px <= cx_last) && (py >= cy) && (py <= cy_last);

  function automatic logic [2:0] solid_colour(input logic solid);
    return solid ? PLAT_COLOUR : COLOUR_BLACK;
  endfunction

  // NOTE: registered state uses non-blocking assignments so every output samples
  // the same pre-edge inputs; the reset branch sits inside the clocked block,
  // which makes it synchronous and discards whatever was in flight.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      bg_colour   <= COLOUR_BLACK;
      char_colour <= COLOUR_NONE;
      coll_down   <= COLOUR_BLACK;
      coll_up     <= COLOUR_BLACK;
      coll_left   <= COLOUR_BLACK;
      coll_right  <= COLOUR_BLACK;
    end else begin
      bg_colour   <= solid_colour(pix_hit && !pix_off);
      char_colour <= char_inside ? CHAR_COLOUR : COLOUR_NONE;
      coll_down   <= solid_colour(down_hit  || down_off);
      coll_up     <= solid_colour(up_hit    || up_off);
      coll_left   <= solid_colour(left_hit  || left_off);
      coll_right  <= solid_colour(right_hit || right_off);
    end
  end

endmodule

// File: tb/tb_scene_platform_engine.sv
// Self-checking bench for scene_platform_engine: directed vector table, latency and
// reset sequences, then random stimulus against a per-pixel reference model.
module tb_scene_platform_engine;

  logic       clock = 1'b0;
  logic       resetn;
  logic [8:0] pix_x, pix_y, char_x, char_y;
  logic [2:0] bg_colour, char_colour, coll_down, coll_up, coll_left, coll_right;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  scene_platform_engine dut (
    .clock      (clock),
    .resetn     (resetn),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .char_x     (char_x),
    .char_y     (char_y),
    .bg_colour  (bg_colour),
    .char_colour(char_colour),
    .coll_down  (coll_down),
    .coll_up    (coll_up),
    .coll_left  (coll_left),
    .coll_right (coll_right)
  );

  typedef struct {
    int         px, py, cx, cy;
    logic [2:0] bg, ch, dn, up, lf, rt;
  } vec_t;

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [2:0] bg, input logic [2:0] ch,
                           input logic [2:0] dn, input logic [2:0] up,
                           input logic [2:0] lf, input logic [2:0] rt);
    check({tag, ".bg"},    bg_colour,   bg);
    check({tag, ".char"},  char_colour, ch);
    check({tag, ".down"},  coll_down,   dn);
    check({tag, ".up"},    coll_up,     up);
    check({tag, ".left"},  coll_left,   lf);
    check({tag, ".right"}, coll_right,  rt);
  endtask

  task automatic drive(input int px, input int py, input int cx, input int cy);
    pix_x  = 9'(px);
    pix_y  = 9'(py);
    char_x = 9'(cx);
    char_y = 9'(cy);
  endtask

  // Reference model: walks the screen pixel by pixel against the platform list.
  int plat_x0[5] = '{0,   80,  180, 0,   310};
  int plat_x1[5] = '{319, 159, 259, 9,   319};
  int plat_y0[5] = '{215, 170, 120, 0,   0};
  int plat_y1[5] = '{239, 179, 129, 239, 239};

  function automatic bit on_platform(input int x, input int y);
    for (int i = 0; i < 5; i++)
      if (x >= plat_x0[i] && x <= plat_x1[i] && y >= plat_y0[i] && y <= plat_y1[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [2:0] probe(input int x0, input int x1, input int y0, input int y1);
    for (int x = x0; x <= x1; x++)
      for (int y = y0; y <= y1; y++)
        if (x < 0 || y < 0 || x > 319 || y > 239 || on_platform(x, y)) return 3'b010;
    return 3'b000;
  endfunction

  task automatic check_model(input string tag, input int px, input int py,
                             input int cx, input int cy);
    logic [2:0] bg, ch;
    bg = on_platform(px, py) ? 3'b010 : 3'b000;
    ch = (px >= cx && px < cx + 10 && py >= cy && py < cy + 10) ? 3'b100 : 3'b111;
    check_all(tag, bg, ch,
              probe(cx, cx + 9, cy + 10, cy + 10),
              probe(cx, cx + 9, cy - 1, cy - 1),
              probe(cx - 1, cx - 1, cy, cy + 9),
              probe(cx + 10, cx + 10, cy, cy + 9));
  endtask

  vec_t vecs[12];

  initial begin
    //             px   py   cx   cy   bg      ch      down    up      left    right
    vecs[0]  = '{ 44, 214,  35, 205, 3'b000, 3'b100, 3'b010, 3'b000, 3'b000, 3'b000};
    vecs[1]  = '{ 45, 214,  35, 205, 3'b000, 3'b111, 3'b010, 3'b000, 3'b000, 3'b000};
    vecs[2]  = '{ 85, 175, 100, 150, 3'b010, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000};
    vecs[3]  = '{ 85, 165, 100, 150, 3'b000, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000};
    vecs[4]  = '{  0,   0, 100, 180, 3'b010, 3'b111, 3'b000, 3'b010, 3'b000, 3'b000};
    vecs[5]  = '{160, 100,  10, 100, 3'b000, 3'b111, 3'b000, 3'b000, 3'b010, 3'b000};
    vecs[6]  = '{305, 105, 300, 100, 3'b000, 3'b100, 3'b000, 3'b000, 3'b000, 3'b010};
    vecs[7]  = '{  0,   0,   0,   0, 3'b010, 3'b100, 3'b010, 3'b010, 3'b010, 3'b000};
    vecs[8]  = '{259, 129, 180, 110, 3'b010, 3'b111, 3'b010, 3'b000, 3'b000, 3'b000};
    vecs[9]  = '{319, 239, 315, 235, 3'b010, 3'b100, 3'b010, 3'b010, 3'b010, 3'b010};
    vecs[10] = '{ 10, 239, 150, 190, 3'b010, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000};
    vecs[11] = '{160, 175, 150, 160, 3'b000, 3'b111, 3'b010, 3'b000, 3'b000, 3'b000};

    resetn = 1'b0;
    drive(0, 0, 0, 0);
    repeat (2) @(posedge clock);
    #1 check_all("reset", 3'b000, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000);

    @(negedge clock) resetn = 1'b1;

    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      drive(vecs[i].px, vecs[i].py, vecs[i].cx, vecs[i].cy);
      @(posedge clock);
      #1 check_all($sformatf("vec%0d", i), vecs[i].bg, vecs[i].ch, vecs[i].dn,
                   vecs[i].up, vecs[i].lf, vecs[i].rt);
    end

    // One-cycle latency: the output must not move before the next edge.
    @(negedge clock) drive(0, 0, 35, 205);
    @(posedge clock);
    #1 check("lat.rest_down", coll_down, 3'b010);
    @(negedge clock) drive(0, 0, 100, 150);
    #1 check("lat.hold_down", coll_down, 3'b010);
    @(posedge clock);
    #1 check("lat.air_down", coll_down, 3'b000);

    // Mid-scan reset discards the in-flight corner result, then operation resumes.
    @(negedge clock);
    drive(0, 0, 0, 0);
    resetn = 1'b0;
    @(posedge clock);
    #1 check_all("midrst", 3'b000, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000);
    @(negedge clock) resetn = 1'b1;
    @(posedge clock);
    #1 check_all("resume", 3'b010, 3'b100, 3'b010, 3'b010, 3'b010, 3'b000);

    for (int n = 0; n < 300; n++) begin
      int px, py, cx, cy;
      px = $urandom_range(0, 319);
      py = $urandom_range(0, 239);
      cx = $urandom_range(0, 330);
      cy = $urandom_range(0, 250);
      if (n % 3 == 0) begin
        px = cx + $urandom_range(0, 11) - 1;
        py = cy + $urandom_range(0, 11) - 1;
        if (px < 0) px = 0;
        if (py < 0) py = 0;
        if (px > 319) px = 319;
        if (py > 239) py = 239;
      end
      @(negedge clock) drive(px, py, cx, cy);
      @(posedge clock);
      #1 check_model($sformatf("rnd%0d", n), px, py, cx, cy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
